// File: rtl/axil_ctrl_regbank.sv
// AXI4-Lite register bank for filter/ADC datapath control.
// Holds NUM_REGS registers of C_S_AXI_DATA_WIDTH bits, each of one of three kinds:
//   - RW  : byte-strobed read/write storage.
//   - W1C : sticky event bits, set by event_in and cleared by writing 1.
//   - RO  : reads return the matching status_in slice; writes get SLVERR.
// Ports:
//   S_AXI_*   AXI4-Lite slave (AW, W, B, AR and R channels)
//   regs_q    flattened register contents, register i at [i*DW +: DW]
//   status_in read values for RO registers
//   event_in  per-bit set requests for W1C registers
//   wr_pulse  high for the commit cycle of each write to register i
//   irq       high while any W1C register holds a set bit
module axil_ctrl_regbank #(
    parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS           = 8,
    parameter int unsigned         C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK           = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   regs_q,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   status_in,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   event_in,
    output logic [NUM_REGS-1:0]                      wr_pulse,
    output logic                                     irq
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W   = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              aw_full;
    logic [IDX_W-1:0]  aw_idx;
    logic              w_full;
    logic [DW-1:0]     w_data;
    logic [STRB_W-1:0] w_strb;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [IDX_W-1:0]  ar_idx;
    logic [DW-1:0]     byte_mask;
    logic              irq_n;

    logic [DW-1:0]     regs       [NUM_REGS];
    logic [DW-1:0]     regs_n     [NUM_REGS];
    logic [DW-1:0]     status_arr [NUM_REGS];
    logic [DW-1:0]     ev_arr     [NUM_REGS];

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    // A write commits once both halves are held and the previous B has drained.
    assign commit = aw_full & w_full & ~S_AXI_BVALID;
    assign ar_idx = IDX_W'(S_AXI_ARADDR >> ADDR_LSB);
    assign S_AXI_RRESP = RESP_OKAY;

    // Unpack flattened buses and expand WSTRB to a bit mask.
    always_comb begin
        byte_mask = '0;
        regs_q    = '0;
        for (int b = 0; b < STRB_W; b++) begin
            byte_mask[b*8 +: 8] = {8{w_strb[b]}};
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            status_arr[i]      = status_in[i*DW +: DW];
            ev_arr[i]          = event_in[i*DW +: DW];
            regs_q[i*DW +: DW] = regs[i];
        end
    end

    // Next register values; on W1C registers an event set overrides a same-cycle clear.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_n[i] = regs[i];
            if (RO_MASK[i]) begin
                regs_n[i] = '0;
            end else if (W1C_MASK[i]) begin
                if (commit && (aw_idx == IDX_W'(i))) begin
                    regs_n[i] = regs[i] & ~(w_data & byte_mask);
                end
                regs_n[i] = regs_n[i] | ev_arr[i];
            end else if (commit && (aw_idx == IDX_W'(i))) begin
                regs_n[i] = (regs[i] & ~byte_mask) | (w_data & byte_mask);
            end
        end
    end

    // Interrupt source: any bit set in any sticky register.
    always_comb begin
        irq_n = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (W1C_MASK[i] && !RO_MASK[i]) begin
                irq_n = irq_n | (|regs[i]);
            end
        end
    end

    // Commit strobe decoded from registered holder state, so it is glitch-free.
    always_comb begin
        wr_pulse = '0;
        if (commit) begin
            wr_pulse[aw_idx] = 1'b1;
        end
    end

    // Write path: AW/W holders and B response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full       <= 1'b0;
            aw_idx        <= '0;
            w_full        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= IDX_W'(S_AXI_AWADDR >> ADDR_LSB);
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            // READY mirrors the next holder occupancy.
            S_AXI_AWREADY <= ~(aw_hs | (aw_full & ~commit));
            S_AXI_WREADY  <= ~(w_hs | (w_full & ~commit));
            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= RO_MASK[aw_idx] ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read path: single outstanding read, data captured on the AR handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= RO_MASK[ar_idx] ? status_arr[ar_idx] : regs[ar_idx];
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
            S_AXI_ARREADY <= ~(ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY));
        end
    end

    // Register storage and interrupt output.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            irq <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= regs_n[i];
            end
            irq <= irq_n;
        end
    end

endmodule

// File: tb/tb_axil_ctrl_regbank.sv
// Self-checking bench for axil_ctrl_regbank (8 x 32-bit, reg7 RO, reg6 W1C).
module tb_axil_ctrl_regbank;

    localparam logic [7:0] RO_M  = 8'h80;
    localparam logic [7:0] W1C_M = 8'h40;

    logic         clk;
    logic         rst_n;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] regs_q;
    logic [255:0] status_in;
    logic [255:0] event_in;
    logic [7:0]   wr_pulse;
    logic         irq;

    axil_ctrl_regbank #(
        .C_S_AXI_DATA_WIDTH (32),
        .NUM_REGS           (8),
        .C_S_AXI_ADDR_WIDTH (5),
        .RO_MASK            (RO_M),
        .W1C_MASK           (W1C_M)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .regs_q        (regs_q),
        .status_in     (status_in),
        .event_in      (event_in),
        .wr_pulse      (wr_pulse),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Write strobes seen per register since the last reset.
    int pulse_cnt [8];
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) pulse_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present AW and W together; returns at the negedge after both are accepted.
    task automatic send_aw_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int   cyc;
        logic af;
        logic wf;
        cyc     = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (awvalid || wvalid) begin
            af = awvalid && awready;
            wf = wvalid && wready;
            @(negedge clk);
            if (af) awvalid = 1'b0;
            if (wf) wvalid = 1'b0;
            cyc++;
            if (cyc > 50) begin
                check("aw_w_accept_timeout", 32'(awvalid | wvalid), 32'd0);
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
        end
    endtask

    task automatic wait_b(input int dly, output logic [1:0] resp);
        int cyc;
        resp = 2'bxx;
        repeat (dly) @(negedge clk);
        bready = 1'b1;
        cyc    = 0;
        while (!bvalid && cyc <= 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bvalid) begin
            check("bvalid_timeout", 32'(bvalid), 32'd1);
        end else begin
            resp = bresp;
            @(negedge clk);
        end
        bready = 1'b0;
    endtask

    task automatic send_ar(input logic [4:0] addr);
        int cyc;
        cyc     = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (arvalid) begin
            if (arready) begin
                @(negedge clk);
                arvalid = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
                if (cyc > 50) begin
                    check("arready_timeout", 32'(arready), 32'd1);
                    arvalid = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_r(input int dly, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        data = 'x;
        resp = 2'bxx;
        repeat (dly) @(negedge clk);
        rready = 1'b1;
        cyc    = 0;
        while (!rvalid && cyc <= 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!rvalid) begin
            check("rvalid_timeout", 32'(rvalid), 32'd1);
        end else begin
            data = rdata;
            resp = rresp;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int dly, output logic [1:0] resp);
        send_aw_w(addr, data, strb);
        wait_b(dly, resp);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int dly,
                            output logic [31:0] data, output logic [1:0] resp);
        send_ar(addr);
        wait_r(dly, data, resp);
    endtask

    // Reference model: byte-lane semantics of each register kind.
    logic [31:0] mdl [8];

    function automatic logic [31:0] model_write(input int idx, input logic [31:0] old,
                                                input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] v;
        v = old;
        if (RO_M[idx]) return old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                if (W1C_M[idx]) v[b*8 +: 8] = old[b*8 +: 8] & ~data[b*8 +: 8];
                else            v[b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return v;
    endfunction

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vt [9];
    logic [1:0]  resp;
    logic [1:0]  rr;
    logic [31:0] rd;
    int          exp_pulse [8];

    initial begin
        vt[0] = '{5'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001};
        vt[1] = '{5'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002};
        vt[2] = '{5'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0000_0003};
        vt[3] = '{5'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0000_0004};
        vt[4] = '{5'h10, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344};
        vt[5] = '{5'h10, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h11BB_33DD};
        vt[6] = '{5'h14, 32'hFFFF_0000, 4'hC, 2'b00, 32'hFFFF_0000};
        vt[7] = '{5'h1C, 32'h1234_5678, 4'hF, 2'b10, 32'hDEAD_BEEF};
        vt[8] = '{5'h01, 32'h0000_0055, 4'h1, 2'b00, 32'h0000_0055};

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        status_in = '0;
        event_in  = '0;
        status_in[7*32 +: 32] = 32'hDEAD_BEEF;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'({awready, wready, arready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_regs_q", 32'(|regs_q), 32'd0);
        check("rst_irq_pulse", 32'({irq, wr_pulse}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", 32'({awready, wready, arready}), 32'h7);

        // Table: write, then read back.
        for (int k = 0; k < 9; k++) begin
            axi_write(vt[k].addr, vt[k].wdata, vt[k].strb, 0, resp);
            check($sformatf("vec%0d_bresp", k), 32'(resp), 32'(vt[k].exp_bresp));
            axi_read(vt[k].addr, 0, rd, rr);
            check($sformatf("vec%0d_rdata", k), rd, vt[k].exp_rdata);
            check($sformatf("vec%0d_rresp", k), 32'(rr), 32'd0);
        end
        check("pulse_cnt_r0", 32'(pulse_cnt[0]), 32'd2);
        check("pulse_cnt_r1", 32'(pulse_cnt[1]), 32'd1);
        check("pulse_cnt_r2", 32'(pulse_cnt[2]), 32'd1);
        check("pulse_cnt_r3", 32'(pulse_cnt[3]), 32'd1);
        check("pulse_cnt_r7", 32'(pulse_cnt[7]), 32'd1);

        // Read and write committing to reg1 in the same cycle: read sees the old value.
        send_aw_w(5'h04, 32'h0000_0200, 4'hF);
        check("same_cycle_pulse", 32'(wr_pulse), 32'h02);
        send_ar(5'h04);
        wait_r(0, rd, rr);
        wait_b(0, resp);
        check("same_cycle_read_old", rd, 32'h0000_0002);
        axi_read(5'h04, 0, rd, rr);
        check("same_cycle_read_new", rd, 32'h0000_0200);

        // W three cycles ahead of AW, B held off, second write queued behind it.
        bready = 1'b0;
        wdata  = 32'hCAFE_0001;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        check("wfirst_wready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("wfirst_holder_full", 32'({wready, awready, bvalid}), 32'b010);
        awaddr  = 5'h08;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_commit_pulse", 32'(wr_pulse), 32'h04);
        send_aw_w(5'h0C, 32'h0000_0077, 4'hF);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bhold%0d_bvalid", c), 32'(bvalid), 32'd1);
            check($sformatf("bhold%0d_bresp", c), 32'(bresp), 32'd0);
            check($sformatf("bhold%0d_ready", c), 32'({awready, wready}), 32'd0);
            check($sformatf("bhold%0d_pulse", c), 32'(wr_pulse), 32'd0);
            @(negedge clk);
        end
        wait_b(0, resp);
        check("wfirst_b1", 32'(resp), 32'd0);
        wait_b(0, resp);
        check("wfirst_b2", 32'(resp), 32'd0);
        axi_read(5'h08, 0, rd, rr);
        check("wfirst_rd_r2", rd, 32'hCAFE_0001);
        axi_read(5'h0C, 0, rd, rr);
        check("wfirst_rd_r3", rd, 32'h0000_0077);

        // Sticky event register 6.
        event_in[6*32 +: 32] = 32'h5;
        @(negedge clk);
        event_in = '0;
        repeat (2) @(negedge clk);
        check("evt_irq_set", 32'(irq), 32'd1);
        axi_read(5'h18, 0, rd, rr);
        check("evt_rd_5", rd, 32'h5);
        axi_write(5'h18, 32'h1, 4'hF, 0, resp);
        check("w1c_bresp", 32'(resp), 32'd0);
        axi_read(5'h18, 0, rd, rr);
        check("w1c_rd_4", rd, 32'h4);
        check("w1c_irq_still", 32'(irq), 32'd1);
        event_in[6*32 + 2] = 1'b1;
        axi_write(5'h18, 32'h4, 4'hF, 0, resp);
        event_in = '0;
        axi_read(5'h18, 0, rd, rr);
        check("w1c_set_wins", rd, 32'h4);
        axi_write(5'h18, 32'h4, 4'hF, 0, resp);
        axi_read(5'h18, 0, rd, rr);
        check("w1c_cleared", rd, 32'h0);
        check("w1c_irq_low", 32'(irq), 32'd0);

        // Reset while a read response is pending and the AW holder is occupied.
        event_in[6*32] = 1'b1;
        @(negedge clk);
        event_in = '0;
        repeat (2) @(negedge clk);
        check("mrst_irq_pre", 32'(irq), 32'd1);
        rready  = 1'b0;
        araddr  = 5'h00;
        arvalid = 1'b1;
        awaddr  = 5'h00;
        awvalid = 1'b1;
        check("mrst_pre_ready", 32'({arready, awready}), 32'b11);
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        check("mrst_pre_state", 32'({rvalid, awready}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("mrst_valids", 32'({bvalid, rvalid}), 32'd0);
        check("mrst_ready", 32'({awready, wready, arready}), 32'd0);
        check("mrst_regs_q", 32'(|regs_q), 32'd0);
        check("mrst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mdl[i]       = '0;
            exp_pulse[i] = 0;
        end
        axi_write(5'h08, 32'h0000_0099, 4'hF, 0, resp);
        mdl[2]       = 32'h0000_0099;
        exp_pulse[2] = 1;
        check("mrst_wr_bresp", 32'(resp), 32'd0);
        axi_read(5'h00, 0, rd, rr);
        check("mrst_rd_r0", rd, 32'h0);
        axi_read(5'h08, 0, rd, rr);
        check("mrst_rd_r2", rd, 32'h0000_0099);

        // Randomised traffic against the reference model.
        status_in[7*32 +: 32] = $urandom;
        for (int n = 0; n < 300; n++) begin
            int          idx;
            logic [4:0]  addr;
            logic [31:0] d;
            logic [3:0]  s;
            idx  = $urandom_range(0, 7);
            addr = {3'(idx), 2'($urandom_range(0, 3))};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                axi_write(addr, d, s, $urandom_range(0, 3), resp);
                mdl[idx] = model_write(idx, mdl[idx], d, s);
                exp_pulse[idx]++;
                check($sformatf("rnd%0d_bresp", n), 32'(resp), RO_M[idx] ? 32'd2 : 32'd0);
                if (!RO_M[idx]) check($sformatf("rnd%0d_regs_q", n), regs_q[idx*32 +: 32], mdl[idx]);
            end else begin
                axi_read(addr, $urandom_range(0, 3), rd, rr);
                check($sformatf("rnd%0d_rdata", n), rd,
                      RO_M[idx] ? status_in[7*32 +: 32] : mdl[idx]);
                check($sformatf("rnd%0d_rresp", n), 32'(rr), 32'd0);
            end
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rnd_pulse_cnt_r%0d", i), 32'(pulse_cnt[i]), 32'(exp_pulse[i]));
        end
        check("rnd_irq", 32'(irq), 32'(|mdl[6]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
